// File: rtl/dual_rail_pkg.sv
// rtl/dual_rail_pkg.sv - shared types and defaults for the dual-rail capture block
//
// Purpose: state and pair-class enums plus default parameter values used by
// dual_rail_capture, its interface and the dual_rail_classifier.
// Ports: none (package).
package dual_rail_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_TIMEOUT = 15;
  localparam int DEFAULT_ERR_W   = 8;

  typedef enum logic [1:0] {
    SPACER_WAIT = 2'd0,
    EVAL_WAIT   = 2'd1,
    OUT_HOLD    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SPACER   = 2'd0,
    PARTIAL  = 2'd1,
    CODEWORD = 2'd2,
    INVALID  = 2'd3
  } pair_class_t;

endpackage

// File: rtl/dual_rail_capture_if.sv
// rtl/dual_rail_capture_if.sv - rail inputs, single-rail output handshake and error flags
//
// Purpose: bundles every non-clock/reset signal of dual_rail_capture.
// Ports (signals):
//   dr_in, dr_inbar   WIDTH  true / complement rails
//   data_out          WIDTH  captured single-rail word
//   data_valid, data_ready   output handshake
//   err_invalid, err_timeout one-cycle error pulses
//   err_count         ERR_W  saturating error count
//   busy                     capture in progress or word held
// Modports: master = rail driver / word consumer, slave = capture block.
interface dual_rail_capture_if import dual_rail_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ERR_W = DEFAULT_ERR_W
);
  logic [WIDTH-1:0] dr_in;
  logic [WIDTH-1:0] dr_inbar;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             err_invalid;
  logic             err_timeout;
  logic [ERR_W-1:0] err_count;
  logic             busy;

  modport master (
    output dr_in, dr_inbar, data_ready,
    input  data_out, data_valid, err_invalid, err_timeout, err_count, busy
  );

  modport slave (
    input  dr_in, dr_inbar, data_ready,
    output data_out, data_valid, err_invalid, err_timeout, err_count, busy
  );
endinterface

// File: rtl/dual_rail_classifier.sv
// rtl/dual_rail_classifier.sv - combinational class of a dual-rail pair vector
//
// Purpose: maps WIDTH true/complement rail pairs to SPACER / PARTIAL /
// CODEWORD / INVALID. INVALID (any pair 11) has priority.
// Ports:
//   rail      in   WIDTH  true rails
//   rail_bar  in   WIDTH  complement rails
//   cls       out  2      pair_class_t
module dual_rail_classifier import dual_rail_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rail,
  input  logic [WIDTH-1:0] rail_bar,
  output pair_class_t      cls
);
  logic any_11;
  logic all_00;
  logic all_one_hot;

  assign any_11      = |(rail & rail_bar);
  assign all_00      = ~|(rail | rail_bar);
  assign all_one_hot = &(rail ^ rail_bar);

  always_comb begin
    cls = PARTIAL;
    if (any_11)
      cls = INVALID;
    else if (all_00)
      cls = SPACER;
    else if (all_one_hot)
      cls = CODEWORD;
  end
endmodule

// File: rtl/dual_rail_capture.sv
// rtl/dual_rail_capture.sv - dual-rail RZ receiver with spacer/codeword protocol check
//
// Purpose: registers the rails, enforces spacer -> codeword ordering, hands
// each codeword out on a valid/ready port and flags invalid pairs and stalled
// evaluations with a saturating error count.
// Ports:
//   clk  in  1  rising-edge clock
//   rst  in  1  asynchronous active-high reset
//   bus  dual_rail_capture_if.slave (rails, output handshake, error flags, busy)
module dual_rail_capture import dual_rail_pkg::*; #(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int ERR_W   = DEFAULT_ERR_W
) (
  input  logic clk,
  input  logic rst,
  dual_rail_capture_if.slave bus
);
  localparam int             TCW     = $clog2(TIMEOUT + 1);
  localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT - 1);

  logic [WIDTH-1:0] rail_q;
  logic [WIDTH-1:0] rail_bar_q;
  logic             sample_ok_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             inv_q;
  logic             to_q;
  logic [ERR_W-1:0] cnt_q;
  logic [TCW-1:0]   tcount_q;

  state_t      state_q;
  state_t      state_d;
  pair_class_t cls_raw;
  pair_class_t cls;

  logic accept;
  logic load_word;
  logic invalid_set;
  logic timeout_set;
  logic tcount_clr;
  logic tcount_inc;

  dual_rail_classifier #(.WIDTH(WIDTH)) u_classifier (
    .rail     (rail_q),
    .rail_bar (rail_bar_q),
    .cls      (cls_raw)
  );

  // The zeros left in the input register by reset are not a real spacer.
  // Until the first genuine sample is taken the register is treated as stale,
  // so a codeword already on the rails at reset release is not captured.
  assign cls    = sample_ok_q ? cls_raw : PARTIAL;
  assign accept = valid_q & bus.data_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= SPACER_WAIT;
    else
      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      SPACER_WAIT: begin
        if (cls == SPACER)
          state_d = EVAL_WAIT;
      end
      EVAL_WAIT: begin
        case (cls)
          CODEWORD: state_d = OUT_HOLD;
          INVALID:  state_d = SPACER_WAIT;
          PARTIAL:  if (tcount_q == TC_LAST) state_d = SPACER_WAIT;
          default:  state_d = EVAL_WAIT;
        endcase
      end
      OUT_HOLD: begin
        if (accept)
          state_d = SPACER_WAIT;
      end
      default: state_d = SPACER_WAIT;
    endcase
  end

  // Output/control decode; errors are only classified outside OUT_HOLD.
  always_comb begin
    load_word   = 1'b0;
    invalid_set = 1'b0;
    timeout_set = 1'b0;
    tcount_clr  = 1'b0;
    tcount_inc  = 1'b0;
    case (state_q)
      SPACER_WAIT: begin
        tcount_clr  = (cls == SPACER);
        invalid_set = (cls == INVALID);
      end
      EVAL_WAIT: begin
        case (cls)
          SPACER:   tcount_clr  = 1'b1;
          CODEWORD: load_word   = 1'b1;
          INVALID:  invalid_set = 1'b1;
          default: begin
            tcount_inc  = 1'b1;
            timeout_set = (tcount_q == TC_LAST);
          end
        endcase
      end
      default: ;
    endcase
  end

  // Input register, output word, error pulses and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rail_q      <= '0;
      rail_bar_q  <= '0;
      sample_ok_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      inv_q       <= 1'b0;
      to_q        <= 1'b0;
      cnt_q       <= '0;
      tcount_q    <= '0;
    end else begin
      rail_q      <= bus.dr_in;
      rail_bar_q  <= bus.dr_inbar;
      sample_ok_q <= 1'b1;
      inv_q       <= invalid_set;
      to_q        <= timeout_set;

      if (load_word) begin
        data_q  <= rail_q;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end

      if (tcount_clr)
        tcount_q <= '0;
      else if (tcount_inc)
        tcount_q <= tcount_q + 1'b1;

      if ((invalid_set || timeout_set) && (cnt_q != {ERR_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.data_out    = data_q;
  assign bus.data_valid  = valid_q;
  assign bus.err_invalid = inv_q;
  assign bus.err_timeout = to_q;
  assign bus.err_count   = cnt_q;
  assign bus.busy        = (state_q == EVAL_WAIT) || (state_q == OUT_HOLD);
endmodule

// File: tb/tb_dual_rail_capture.sv
// tb/tb_dual_rail_capture.sv - self-checking bench for dual_rail_capture
module tb_dual_rail_capture;
  localparam int W  = 8;
  localparam int TO = 15;
  localparam int EW = 8;

  localparam int C_STALE = -1;
  localparam int C_SP    = 0;
  localparam int C_PART  = 1;
  localparam int C_CW    = 2;
  localparam int C_INV   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dual_rail_capture_if #(.WIDTH(W), .ERR_W(EW)) bus ();

  dual_rail_capture #(.WIDTH(W), .TIMEOUT(TO), .ERR_W(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Protocol model: "armed" means a fresh spacer has been seen and an
  // evaluation is awaited; "held" means a word is waiting for the consumer.
  bit         m_armed, m_held, m_samp_ok, m_inv, m_to;
  int         m_run, m_cnt;
  logic [7:0] m_word, m_a, m_b;

  function automatic int classify(input logic [7:0] a, input logic [7:0] b);
    int n11 = 0;
    int n00 = 0;
    for (int i = 0; i < W; i++) begin
      if (a[i] && b[i]) n11++;
      if (!a[i] && !b[i]) n00++;
    end
    if (n11 > 0) return C_INV;
    if (n00 == W) return C_SP;
    if (n00 == 0) return C_CW;
    return C_PART;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_held = 0; m_samp_ok = 0; m_inv = 0; m_to = 0;
    m_run = 0; m_cnt = 0; m_word = 0; m_a = 0; m_b = 0;
  endtask

  task automatic model_edge(input logic [7:0] a, input logic [7:0] b, input bit r);
    int c;
    c = m_samp_ok ? classify(m_a, m_b) : C_STALE;
    m_inv = 0;
    m_to  = 0;
    if (m_held) begin
      if (r) m_held = 0;
    end else if (!m_armed) begin
      if (c == C_SP) begin m_armed = 1; m_run = 0; end
      else if (c == C_INV) m_inv = 1;
    end else begin
      if (c == C_CW) begin m_word = m_a; m_held = 1; m_armed = 0; end
      else if (c == C_INV) begin m_inv = 1; m_armed = 0; end
      else if (c == C_SP) m_run = 0;
      else begin
        m_run++;
        if (m_run == TO) begin m_to = 1; m_armed = 0; end
      end
    end
    if ((m_inv || m_to) && m_cnt < (1 << EW) - 1) m_cnt++;
    m_a = a; m_b = b; m_samp_ok = 1;
  endtask

  // Inputs change away from the edge; outputs are read 1ns after it.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input bit r);
    bus.dr_in = a; bus.dr_inbar = b; bus.data_ready = r;
    @(posedge clk);
    model_edge(a, b, r);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    rst = 1'b1; bus.dr_in = a; bus.dr_inbar = b; bus.data_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; bus.dr_in = 8'h0A; bus.dr_inbar = 8'hF5; bus.data_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.data_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.data_valid); else n_pass++;
    n_checks++; if (bus.data_out !== 8'h00) $display("FAIL reset_data: got %h expected 00", bus.data_out); else n_pass++;
    n_checks++; if (bus.err_count !== 8'd0) $display("FAIL reset_count: got %0d expected 0", bus.err_count); else n_pass++;
    n_checks++; if ({bus.err_invalid, bus.err_timeout, bus.busy} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {bus.err_invalid, bus.err_timeout, bus.busy}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic_capture();
    do_reset(8'h00, 8'h00);
    step(8'h00, 8'h00, 1);
    step(8'h00, 8'h00, 1);
    step(8'h0A, 8'hF5, 1);
    n_checks++; if (bus.data_valid !== 1'b0) $display("FAIL basic_early_valid: got %b expected 0", bus.data_valid); else n_pass++;
    step(8'h0A, 8'hF5, 1);
    n_checks++; if (bus.data_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", bus.data_valid); else n_pass++;
    n_checks++; if (bus.data_out !== 8'h0A) $display("FAIL basic_data: got %h expected 0a", bus.data_out); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL basic_busy_hold: got %b expected 1", bus.busy); else n_pass++;
    step(8'h00, 8'h00, 1);
    n_checks++; if (bus.data_valid !== 1'b0) $display("FAIL basic_one_cycle_valid: got %b expected 0", bus.data_valid); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL basic_busy_drop: got %b expected 0", bus.busy); else n_pass++;
  endtask

  task automatic test_stale_word();
    int seen = 0;
    do_reset(8'h14, 8'hEB);
    for (int i = 0; i < 4; i++) begin
      step(8'h14, 8'hEB, 1);
      if (bus.data_valid === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL stale_ignored: got %0d valid cycles expected 0", seen); else n_pass++;
    step(8'h00, 8'h00, 1);
    step(8'h14, 8'hEB, 1);
    step(8'h14, 8'hEB, 1);
    n_checks++; if (bus.data_valid !== 1'b1) $display("FAIL stale_then_valid: got %b expected 1", bus.data_valid); else n_pass++;
    n_checks++; if (bus.data_out !== 8'h14) $display("FAIL stale_then_data: got %h expected 14", bus.data_out); else n_pass++;
    step(8'h00, 8'h00, 1);
  endtask

  task automatic test_invalid_pair();
    do_reset(8'h00, 8'h00);
    step(8'h00, 8'h00, 1);
    step(8'h00, 8'h00, 1);
    step(8'h01, 8'h01, 1);
    n_checks++; if (bus.err_invalid !== 1'b0) $display("FAIL inv_early: got %b expected 0", bus.err_invalid); else n_pass++;
    step(8'h00, 8'h00, 1);
    n_checks++; if (bus.err_invalid !== 1'b1) $display("FAIL inv_pulse: got %b expected 1", bus.err_invalid); else n_pass++;
    n_checks++; if (bus.err_count !== 8'd1) $display("FAIL inv_count: got %0d expected 1", bus.err_count); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL inv_to_spacer_wait: got busy %b expected 0", bus.busy); else n_pass++;
    step(8'h00, 8'h00, 1);
    n_checks++; if (bus.err_invalid !== 1'b0) $display("FAIL inv_one_cycle: got %b expected 0", bus.err_invalid); else n_pass++;
    n_checks++; if (bus.data_valid !== 1'b0) $display("FAIL inv_no_valid: got %b expected 0", bus.data_valid); else n_pass++;
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int where  = -1;
    do_reset(8'h00, 8'h00);
    step(8'h00, 8'h00, 1);
    step(8'h00, 8'h00, 1);
    for (int i = 0; i < 20; i++) begin
      step(8'h0A, 8'h00, 1);
      if (bus.err_timeout === 1'b1) begin pulses++; where = i; end
    end
    n_checks++; if (pulses !== 1) $display("FAIL timeout_pulses: got %0d expected 1", pulses); else n_pass++;
    n_checks++; if (where !== TO) $display("FAIL timeout_position: got %0d expected %0d", where, TO); else n_pass++;
    n_checks++; if (bus.err_count !== 8'd1) $display("FAIL timeout_count: got %0d expected 1", bus.err_count); else n_pass++;
    step(8'h00, 8'h00, 1);
    step(8'h0A, 8'hF5, 1);
    step(8'h0A, 8'hF5, 1);
    n_checks++; if ({bus.data_valid, bus.data_out} !== {1'b1, 8'h0A}) $display("FAIL timeout_recover: got %b/%h expected 1/0a", bus.data_valid, bus.data_out); else n_pass++;
    step(8'h00, 8'h00, 1);
  endtask

  task automatic test_backpressure();
    logic [7:0] seq_a [5] = '{8'h00, 8'h00, 8'h14, 8'h14, 8'h14};
    logic [7:0] seq_b [5] = '{8'h00, 8'h00, 8'hEB, 8'hEB, 8'hEB};
    int bad = 0;
    int seen = 0;
    do_reset(8'h00, 8'h00);
    step(8'h00, 8'h00, 0);
    step(8'h00, 8'h00, 0);
    step(8'h0A, 8'hF5, 0);
    step(8'h0A, 8'hF5, 0);
    for (int i = 0; i < 5; i++) begin
      step(seq_a[i], seq_b[i], 0);
      if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h0A) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL bp_hold_stable: got %0d unstable cycles expected 0", bad); else n_pass++;
    step(8'h14, 8'hEB, 1);
    n_checks++; if (bus.data_valid !== 1'b0) $display("FAIL bp_accept: got %b expected 0", bus.data_valid); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step(8'h14, 8'hEB, 1);
      if (bus.data_valid === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL bp_needs_spacer: got %0d valid cycles expected 0", seen); else n_pass++;
    step(8'h00, 8'h00, 1);
    step(8'h14, 8'hEB, 1);
    step(8'h14, 8'hEB, 1);
    n_checks++; if ({bus.data_valid, bus.data_out} !== {1'b1, 8'h14}) $display("FAIL bp_next_word: got %b/%h expected 1/14", bus.data_valid, bus.data_out); else n_pass++;
    step(8'h00, 8'h00, 1);
  endtask

  task automatic test_reset_mid_hold();
    do_reset(8'h00, 8'h00);
    step(8'h00, 8'h00, 0);
    step(8'h00, 8'h00, 0);
    step(8'h0A, 8'hF5, 0);
    step(8'h0A, 8'hF5, 0);
    n_checks++; if (bus.data_valid !== 1'b1) $display("FAIL midhold_setup: got %b expected 1", bus.data_valid); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if ({bus.data_valid, bus.data_out} !== 9'h000) $display("FAIL midhold_async: got %b/%h expected 0/00", bus.data_valid, bus.data_out); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL midhold_busy: got %b expected 0", bus.busy); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_saturation();
    do_reset(8'h01, 8'h01);
    for (int i = 0; i < 301; i++) begin
      step(8'h01, 8'h01, 0);
      if (i == 100) begin
        n_checks++; if (bus.err_count !== 8'(m_cnt)) $display("FAIL sat_midway: got %0d expected %0d", bus.err_count, m_cnt); else n_pass++;
      end
    end
    n_checks++; if (bus.err_count !== 8'd255) $display("FAIL sat_hold: got %0d expected 255", bus.err_count); else n_pass++;
    n_checks++; if (bus.err_invalid !== 1'b1) $display("FAIL sat_pulse: got %b expected 1", bus.err_invalid); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    int sel, hold;
    bit r;
    do_reset(8'h00, 8'h00);
    for (int n = 0; n < 500; n++) begin
      sel = $urandom_range(0, 9);
      a = 8'($urandom);
      if (sel <= 3) begin a = 8'h00; b = 8'h00; end
      else if (sel <= 6) b = ~a;
      else if (sel <= 8) b = ~a & 8'($urandom);
      else b = 8'($urandom);
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) begin
        r = ($urandom_range(0, 3) != 0);
        step(a, b, r);
        n_checks++; if (bus.data_valid !== m_held) $display("FAIL rnd_valid cyc %0d: got %b expected %b", n, bus.data_valid, m_held); else n_pass++;
        if (m_held) begin
          n_checks++; if (bus.data_out !== m_word) $display("FAIL rnd_data cyc %0d: got %h expected %h", n, bus.data_out, m_word); else n_pass++;
        end
        n_checks++; if ({bus.err_invalid, bus.err_timeout} !== {m_inv, m_to}) $display("FAIL rnd_err cyc %0d: got %b expected %b", n, {bus.err_invalid, bus.err_timeout}, {m_inv, m_to}); else n_pass++;
        n_checks++; if (bus.err_count !== 8'(m_cnt)) $display("FAIL rnd_count cyc %0d: got %0d expected %0d", n, bus.err_count, m_cnt); else n_pass++;
        n_checks++; if (bus.busy !== (m_armed | m_held)) $display("FAIL rnd_busy cyc %0d: got %b expected %b", n, bus.busy, m_armed | m_held); else n_pass++;
      end
    end
  endtask

  initial begin
    bus.dr_in = '0;
    bus.dr_inbar = '0;
    bus.data_ready = 1'b0;
    model_reset();
    test_reset();
    test_basic_capture();
    test_stale_word();
    test_invalid_pair();
    test_timeout();
    test_backpressure();
    test_reset_mid_hold();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dual_rail_capture.md
Name: dual_rail_capture

Overview:
- Receive end of the dual-rail return-to-zero interface driven by the LUT circuits (out/outbar pairs).
- Samples the WIDTH-bit true/complement rails and enforces the spacer → codeword protocol.
- Converts each valid codeword to single-rail data with a valid/ready handshake.
- Flags invalid pairs and stalled evaluations, and keeps a saturating error count.

Parameters:
- WIDTH, 8: number of dual-rail bit pairs.
- TIMEOUT, 15: maximum cycles a PARTIAL word may persist in EVAL_WAIT.
- ERR_W, 8: width of the error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- dr_in  in  WIDTH  true rails.
- dr_inbar  in  WIDTH  complement rails.
- data_out  out  WIDTH  captured single-rail word (the true rails).
- data_valid  out  1  data_out holds an unconsumed word.
- data_ready  in  1  consumer accepts the word when data_valid=1.
- err_invalid  out  1  one-cycle pulse: some pair sampled 11.
- err_timeout  out  1  one-cycle pulse: PARTIAL exceeded TIMEOUT.
- err_count  out  ERR_W  saturating count of all error pulses.
- busy  out  1  high in EVAL_WAIT and OUT_HOLD.

Behaviour:
- Reset: one clock (clk) and an asynchronous, active-high reset (rst), as already decided.
  - On rst, all outputs and the input register go to 0, the timeout counter clears, and state = SPACER_WAIT.
  - The effect is immediate, including mid-handshake.
- Input stage: dr_in/dr_inbar are registered on every edge (1-cycle input register).
- Classification of the registered pair vector:
  - SPACER: all pairs 00.
  - INVALID: any pair 11; this has priority.
  - CODEWORD: every pair is 01 or 10.
  - PARTIAL: anything else.
- SPACER_WAIT:
  - SPACER → EVAL_WAIT and clear the timeout counter.
  - INVALID → pulse err_invalid and stay.
  - CODEWORD or PARTIAL → stay. These are stale data from before a precharge and are silently ignored.
- EVAL_WAIT:
  - CODEWORD → load data_out with the registered true rails, set data_valid, go to OUT_HOLD.
  - INVALID → pulse err_invalid, go to SPACER_WAIT.
  - PARTIAL → increment the timeout counter. When it reaches TIMEOUT, pulse err_timeout and go to SPACER_WAIT.
  - SPACER → stay and clear the timeout counter.
- OUT_HOLD:
  - data_out and data_valid are stable while data_ready=0. Inputs are not classified for errors.
  - On a cycle with data_valid & data_ready: clear data_valid next edge, go to SPACER_WAIT.
  - A fresh spacer is therefore required before the next word, even if the rails already returned to zero during the hold.
- Latency: inputs settled to a codeword before edge k are registered at k. data_valid=1 and data_out are visible after edge k+1, i.e. 2 cycles pin-to-valid.
- Minimum word period: 4 cycles (spacer sample, codeword sample, valid, accept).
- err_count:
  - Increments by 1 on each err_invalid or err_timeout pulse (at most one per cycle).
  - Saturates at 2^ERR_W−1.
  - Cleared only by rst.
- Simultaneous events: if rst is asserted it wins over everything. In EVAL_WAIT, INVALID wins over the timeout expiring.

Decomposition:
- Package dual_rail_pkg holds:
  - the state enum (SPACER_WAIT, EVAL_WAIT, OUT_HOLD);
  - the class enum (SPACER, PARTIAL, CODEWORD, INVALID);
  - the default WIDTH/TIMEOUT constants.
- Sub-module dual_rail_classifier: purely combinational, WIDTH-parameterised, maps the rail pair vectors to the class enum. It is reusable by future dual-rail checkers.

Test Plan:
- Basic capture: reset; dr_in=0x00/dr_inbar=0x00 for 2 cycles; then 0x0A/0xF5 with data_ready=1 → data_valid=1 exactly 2 cycles after the codeword is applied, data_out=0x0A, one-cycle valid, busy drops after accept.
- Stale word: release reset with 0x14/0xEB already applied → no data_valid. Then spacer, then 0x14/0xEB → data_out=0x14.
- Invalid pair: after spacer, apply 0x01/0x01 → err_invalid pulses for 1 cycle, err_count=1, state returns to SPACER_WAIT, no data_valid.
- Timeout: after spacer, hold 0x0A/0x00 for 20 cycles → err_timeout pulses once, 15 cycles after the first PARTIAL sample; err_count increments by 1; a later spacer + 0x0A/0xF5 is captured normally.
- Backpressure:
  - Capture 0x0A, then hold data_ready=0 for 5 cycles while the inputs go to spacer then 0x14/0xEB → data_out stays 0x0A, data_valid stays high.
  - After accept, 0x14 is not captured until a new spacer is applied.
- Reset mid-hold and saturation:
  - Assert rst while data_valid=1 → data_valid and data_out are 0 before the next edge.
  - Force 300 invalid events → err_count holds at 255.
